vec_mag_pipe: RTL
=================

Name: vec_mag_pipe

Overview:
Parametrised, fully back-pressured AXI-Stream vector-magnitude pipeline. Computes |v| ≈ alpha·max(|dx|,|dy|) + beta·min(|dx|,|dy|) for v = (x2−x1, y2−y1), with signed coordinates and runtime-programmable coefficients. Rounding and saturation are explicit, and tlast is carried through. It is the next-generation magnitude core for the stream datapath, sitting between the coordinate packer and the result FIFO.

Parameters:
COORD_WIDTH, 8, width of each signed two's-complement coordinate.
COEFF_WIDTH, 6, width of unsigned alpha/beta coefficients.
FRAC_BITS, 5, fractional bits of the coefficients (value = coeff / 2^FRAC_BITS).
OUT_WIDTH, 9, width of the unsigned magnitude output.
ALPHA_INIT, 32, alpha after reset (1.0).
BETA_INIT, 5, beta after reset (5/32).

Ports:
aclk  in  1  clock, all logic on rising edge.
areset  in  1  synchronous, active-high reset.
cfg_we  in  1  coefficient write strobe.
cfg_alpha  in  COEFF_WIDTH  alpha value, loaded when cfg_we=1.
cfg_beta  in  COEFF_WIDTH  beta value, loaded when cfg_we=1.
s_axis_tdata  in  4*COORD_WIDTH  {x1,y1,x2,y2}, x1 in the MSBs.
s_axis_tvalid  in  1  input beat valid.
s_axis_tlast  in  1  input packet end.
s_axis_tready  out  1  input beat accepted when tvalid & tready.
m_axis_tdata  out  OUT_WIDTH  unsigned magnitude.
m_axis_tvalid  out  1  output beat valid.
m_axis_tlast  out  1  s_axis_tlast of the same beat.
m_axis_tuser  out  1  1 = result saturated.

Behaviour:
- Reset (areset=1 at a clock edge): all stage valids 0; m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0; active coefficients = ALPHA_INIT/BETA_INIT. Reset mid-operation discards all in-flight beats.
- Five register stages, S0..S4; each holds valid, tlast and payload. Latency = 5 cycles from acceptance to m_axis_tvalid when not stalled. Throughput is 1 beat/cycle.
- Handshake: stage k loads when !valid_k or ready_{k+1}. ready_5 = m_axis_tready. s_axis_tready = !valid_0 or ready_1, which is a combinational ready chain. Bubbles collapse. Held data is stable while valid and not ready. No beat is dropped or duplicated.
- Coefficients: cfg_we updates the active alpha/beta at the clock edge. S0 snapshots the active alpha/beta with every accepted beat, and the snapshot travels with the beat. A beat accepted on the same edge as cfg_we uses the old values. In-flight beats are never affected.
- S1: dx = x2−x1, dy = y2−y1, computed sign-extended to COORD_WIDTH+1 bits, so there is no overflow.
- S2: |dx|, |dy| as COORD_WIDTH+1-bit unsigned values (exact, including 2^COORD_WIDTH−1 extremes).
- S3: mx = larger, mn = smaller. Ties give mx = mn = |dx|.
- S4: acc = alpha·mx + beta·mn + 2^(FRAC_BITS−1), full precision (COORD_WIDTH+COEFF_WIDTH+2 bits). r = acc >> FRAC_BITS (round half up). If r > 2^OUT_WIDTH−1, output the all-ones value and set tuser=1; otherwise output r with tuser=0.
- Zero vector → 0. alpha=beta=0 → 0.

Optional Feature:
MAG_MAX_CLAMP_EN — when defined, S4 outputs max(r, mx) before saturation. This guarantees the result is never below the dominant component when alpha < 1. When undefined, the output is r only; the logic is absent.

Test Plan:
- Reset defaults, input (x1,y1,x2,y2)=(0,0,10,0), m_axis_tready=1 -> after 5 cycles tdata=10, tuser=0, tlast echoed.
- (0,0,3,4), defaults -> 159>>5 = 4. (-128,-128,127,127) -> 32·255+5·255+16 = 9451 -> 295, tuser=0.
- cfg alpha=63, beta=63, then (-128,-128,127,127) -> 32146>>5 = 1004 > 511 -> tdata=511, tuser=1. A beat accepted in the cfg_we cycle still yields 295.
- Back-pressure: stream 8 beats with random m_axis_tready (including 10 cycles held low with the pipe full) -> s_axis_tready drops, outputs are in order, none lost or duplicated, and held tdata is stable.
- alpha=30, beta=12, (0,0,10,0) -> 9 without MAG_MAX_CLAMP_EN, 10 with it.
- areset asserted for 1 cycle with 3 beats in flight -> m_axis_tvalid=0 next cycle; no stale beat appears afterwards; coefficients return to 32/5.

Source files
------------

// File: rtl/vec_mag_pipe_if.sv
// AXI-Stream style bundle for vec_mag_pipe: coordinate input stream and magnitude output stream.
// slave modport is the pipeline side, master modport is the producer/consumer side.
interface vec_mag_pipe_if #(
  parameter int unsigned COORD_WIDTH = 8,
  parameter int unsigned OUT_WIDTH   = 9
);
  logic [4*COORD_WIDTH-1:0] s_axis_tdata;
  logic                     s_axis_tvalid;
  logic                     s_axis_tlast;
  logic                     s_axis_tready;
  logic [OUT_WIDTH-1:0]     m_axis_tdata;
  logic                     m_axis_tvalid;
  logic                     m_axis_tlast;
  logic                     m_axis_tuser;
  logic                     m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    input  m_axis_tready
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    output m_axis_tready
  );
endinterface

// File: rtl/vec_mag_pipe.sv
// Five-stage back-pressured vector magnitude: alpha*max(|dx|,|dy|) + beta*min(|dx|,|dy|), rounded.
// Optional MAG_MAX_CLAMP_EN: output is never below the dominant component.
module vec_mag_pipe #(
  parameter int unsigned COORD_WIDTH = 8,
  parameter int unsigned COEFF_WIDTH = 6,
  parameter int unsigned FRAC_BITS   = 5,
  parameter int unsigned OUT_WIDTH   = 9,
  parameter int unsigned ALPHA_INIT  = 32,
  parameter int unsigned BETA_INIT   = 5
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   cfg_we,
  input  logic [COEFF_WIDTH-1:0] cfg_alpha,
  input  logic [COEFF_WIDTH-1:0] cfg_beta,
  vec_mag_pipe_if.slave          bus
);
  localparam int unsigned CW = COORD_WIDTH;
  localparam int unsigned DW = COORD_WIDTH + 1;
  localparam int unsigned AW = COORD_WIDTH + COEFF_WIDTH + 2;
  localparam logic [AW-1:0] Half = AW'(1) << (FRAC_BITS - 1);

  logic [COEFF_WIDTH-1:0] alpha_q, beta_q;
  logic [4:0] vld_q, lst_q;
  logic rdy_0, rdy_1, rdy_2, rdy_3, rdy_4;

  logic signed [CW-1:0] x1_q, y1_q, x2_q, y2_q;
  logic signed [DW-1:0] dx_q, dy_q, dx_d, dy_d;
  logic [DW-1:0] adx_q, ady_q, adx_d, ady_d;
  logic [DW-1:0] mx_q, mn_q, mx_d, mn_d;
  logic [COEFF_WIDTH-1:0] a0_q, b0_q, a1_q, b1_q, a2_q, b2_q, a3_q, b3_q;
  logic [OUT_WIDTH-1:0] mag_q, mag_d;
  logic sat_q, sat_d;
  logic [AW-1:0] acc, r;

  // Combinational ready chain lets bubbles collapse at full throughput.
  assign rdy_4 = !vld_q[4] || bus.m_axis_tready;
  assign rdy_3 = !vld_q[3] || rdy_4;
  assign rdy_2 = !vld_q[2] || rdy_3;
  assign rdy_1 = !vld_q[1] || rdy_2;
  assign rdy_0 = !vld_q[0] || rdy_1;

  assign bus.s_axis_tready = rdy_0;
  assign bus.m_axis_tdata  = mag_q;
  assign bus.m_axis_tvalid = vld_q[4];
  assign bus.m_axis_tlast  = lst_q[4];
  assign bus.m_axis_tuser  = sat_q;

  always_comb begin
    dx_d  = {x2_q[CW-1], x2_q} - {x1_q[CW-1], x1_q};
    dy_d  = {y2_q[CW-1], y2_q} - {y1_q[CW-1], y1_q};
    adx_d = dx_q[DW-1] ? $unsigned(-dx_q) : $unsigned(dx_q);
    ady_d = dy_q[DW-1] ? $unsigned(-dy_q) : $unsigned(dy_q);
    mx_d  = (adx_q >= ady_q) ? adx_q : ady_q;
    mn_d  = (adx_q >= ady_q) ? ady_q : adx_q;
    acc   = AW'(a3_q) * AW'(mx_q) + AW'(b3_q) * AW'(mn_q) + Half;
    r     = acc >> FRAC_BITS;
`ifdef MAG_MAX_CLAMP_EN
    if (r < AW'(mx_q)) r = AW'(mx_q);
`endif
    sat_d = (r >> OUT_WIDTH) != '0;
    mag_d = sat_d ? '1 : r[OUT_WIDTH-1:0];
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      alpha_q <= COEFF_WIDTH'(ALPHA_INIT);
      beta_q  <= COEFF_WIDTH'(BETA_INIT);
    end else if (cfg_we) begin
      alpha_q <= cfg_alpha;
      beta_q  <= cfg_beta;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      vld_q <= '0;
      lst_q <= '0;
    end else begin
      if (rdy_0) begin
        vld_q[0] <= bus.s_axis_tvalid;
        lst_q[0] <= bus.s_axis_tlast;
      end
      if (rdy_1) begin
        vld_q[1] <= vld_q[0];
        lst_q[1] <= lst_q[0];
      end
      if (rdy_2) begin
        vld_q[2] <= vld_q[1];
        lst_q[2] <= lst_q[1];
      end
      if (rdy_3) begin
        vld_q[3] <= vld_q[2];
        lst_q[3] <= lst_q[2];
      end
      if (rdy_4) begin
        vld_q[4] <= vld_q[3];
        lst_q[4] <= lst_q[3];
      end
    end
  end

  // Coefficients are snapshotted at S0 and travel with the beat.
  always_ff @(posedge aclk) begin
    if (areset) begin
      {x1_q, y1_q, x2_q, y2_q} <= '0;
      {dx_q, dy_q, adx_q, ady_q, mx_q, mn_q} <= '0;
      {a0_q, b0_q, a1_q, b1_q, a2_q, b2_q, a3_q, b3_q} <= '0;
      mag_q <= '0;
      sat_q <= 1'b0;
    end else begin
      if (rdy_0) begin
        {x1_q, y1_q, x2_q, y2_q} <= bus.s_axis_tdata;
        a0_q <= alpha_q;
        b0_q <= beta_q;
      end
      if (rdy_1) begin
        dx_q <= dx_d;
        dy_q <= dy_d;
        a1_q <= a0_q;
        b1_q <= b0_q;
      end
      if (rdy_2) begin
        adx_q <= adx_d;
        ady_q <= ady_d;
        a2_q  <= a1_q;
        b2_q  <= b1_q;
      end
      if (rdy_3) begin
        mx_q <= mx_d;
        mn_q <= mn_d;
        a3_q <= a2_q;
        b3_q <= b2_q;
      end
      if (rdy_4) begin
        mag_q <= mag_d;
        sat_q <= sat_d;
      end
    end
  end
endmodule
